// File: rtl/occupancy_pkg.sv
// ============================================================================
// Module : occupancy_pkg
// Brief  : Shared widths, cell/class types and reader states for the
//          occupancy-grid read side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package occupancy_pkg;

  localparam int X_WIDTH    = 5;
  localparam int Y_WIDTH    = 4;
  localparam int CELL_WIDTH = 8;
  localparam int GRID_CELLS = 512;
  localparam int ADDR_WIDTH = 9;
  localparam int FIFO_DEPTH = 2;

  typedef logic signed [CELL_WIDTH-1:0] cell_t;

  typedef enum logic [1:0] {
    CLASS_UNKNOWN  = 2'b00,
    CLASS_FREE     = 2'b01,
    CLASS_OCCUPIED = 2'b10
  } cell_class_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DUMP   = 2'd2
  } reader_state_t;

  // Signed log-odds comparison; occupied takes priority if thresholds overlap.
  function automatic cell_class_t classify_cell(input cell_t value,
                                                input cell_t occ_thr,
                                                input cell_t free_thr);
    if (value >= occ_thr) begin
      return CLASS_OCCUPIED;
    end else if (value <= free_thr) begin
      return CLASS_FREE;
    end else begin
      return CLASS_UNKNOWN;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/occupancy_reader_index_to_address.sv
// ============================================================================
// Module : index_to_address
// Brief  : Maps a grid (x,y) index to the row-major RAM address {y,x}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module index_to_address
  import occupancy_pkg::*;
(
  input  logic [X_WIDTH-1:0]    x,
  input  logic [Y_WIDTH-1:0]    y,
  output logic [ADDR_WIDTH-1:0] address
);

  assign address = {y, x};

endmodule

`default_nettype wire

// File: rtl/occupancy_reader.sv
// ============================================================================
// Module : occupancy_reader
// Brief  : Read side of the 32x16 occupancy grid RAM: single-cell lookups and
//          full raster dumps through a 2-entry credit-managed output FIFO.
//          Define OCCUPANCY_READER_THRESHOLD_EN to add the resp_class output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module occupancy_reader
  import occupancy_pkg::*;
`ifdef OCCUPANCY_READER_THRESHOLD_EN
#(
  parameter cell_t OCC_THRESHOLD  = 8'sd20,
  parameter cell_t FREE_THRESHOLD = -8'sd20
)
`endif
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_active,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [X_WIDTH-1:0]    req_x,
  input  logic [Y_WIDTH-1:0]    req_y,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [CELL_WIDTH-1:0] mem_read_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [CELL_WIDTH-1:0] resp_data,
  output logic                  resp_last
`ifdef OCCUPANCY_READER_THRESHOLD_EN
  ,
  output logic [1:0]            resp_class
`endif
);

  reader_state_t          state;
  reader_state_t          state_next;

  logic [1:0]             fifo_count;
  logic                   fifo_wr_ptr;
  logic                   fifo_rd_ptr;
  cell_t                  fifo_data [FIFO_DEPTH];
  logic                   fifo_last [FIFO_DEPTH];

  logic                   inflight;
  logic                   inflight_last;

  logic [ADDR_WIDTH-1:0]  dump_idx;
  logic                   dump_done;

  logic [X_WIDTH-1:0]     lk_x;
  logic [Y_WIDTH-1:0]     lk_y;
  logic                   lk_issued;

  logic [X_WIDTH-1:0]     last_x;
  logic [Y_WIDTH-1:0]     last_y;
  logic [X_WIDTH-1:0]     issue_x;
  logic [Y_WIDTH-1:0]     issue_y;
  logic                   issue;
  logic                   issue_last;

  logic                   push;
  logic                   pop;
  logic                   has_credit;
  logic                   read_ok;
  logic                   req_fire;

  assign resp_valid = (fifo_count != 2'd0);
  assign resp_data  = fifo_data[fifo_rd_ptr];
  assign resp_last  = fifo_last[fifo_rd_ptr];
  assign dump_busy  = (state == DUMP);
  assign req_ready  = (state == IDLE) && !reset;
  assign req_fire   = req_valid && req_ready;

  assign push = inflight;
  assign pop  = resp_valid && resp_ready;

  // A beat leaving this cycle frees its slot, which keeps a dump at one beat
  // per cycle; the FIFO still never holds more than two entries.
  assign has_credit = ((fifo_count + {1'b0, inflight}) < 2'(FIFO_DEPTH)) || pop;
  assign read_ok    = !reset && !write_active && has_credit;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_x    = last_x;
    issue_y    = last_y;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_next = LOOKUP;
          if (read_ok) begin
            issue   = 1'b1;
            issue_x = req_x;
            issue_y = req_y;
          end
        end else if (dump_start) begin
          state_next = DUMP;
        end
      end
      LOOKUP: begin
        if (!lk_issued && read_ok) begin
          issue   = 1'b1;
          issue_x = lk_x;
          issue_y = lk_y;
        end
        if (pop) begin
          state_next = IDLE;
        end
      end
      DUMP: begin
        if (!dump_done && read_ok) begin
          issue      = 1'b1;
          issue_x    = dump_idx[X_WIDTH-1:0];
          issue_y    = dump_idx[ADDR_WIDTH-1:X_WIDTH];
          issue_last = (dump_idx == ADDR_WIDTH'(GRID_CELLS - 1));
        end
        if (pop && resp_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The address is the freshly selected index on an issue cycle, else the last one.
  index_to_address u_index_to_address (
    .x       (issue_x),
    .y       (issue_y),
    .address (mem_address)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      fifo_count    <= 2'd0;
      fifo_wr_ptr   <= 1'b0;
      fifo_rd_ptr   <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      dump_idx      <= '0;
      dump_done     <= 1'b0;
      lk_x          <= '0;
      lk_y          <= '0;
      lk_issued     <= 1'b0;
      last_x        <= '0;
      last_y        <= '0;
    end else begin
      state         <= state_next;
      inflight      <= issue;
      inflight_last <= issue_last;

      if (issue) begin
        last_x <= issue_x;
        last_y <= issue_y;
      end

      if (state == IDLE && req_fire) begin
        lk_x      <= req_x;
        lk_y      <= req_y;
        lk_issued <= issue;
      end else if (state == LOOKUP && issue) begin
        lk_issued <= 1'b1;
      end

      if (state == IDLE) begin
        dump_idx  <= '0;
        dump_done <= 1'b0;
      end else if (state == DUMP && issue) begin
        if (issue_last) begin
          dump_done <= 1'b1;
        end else begin
          dump_idx <= dump_idx + 1'b1;
        end
      end

      if (push) begin
        fifo_data[fifo_wr_ptr] <= mem_read_data;
        fifo_last[fifo_wr_ptr] <= inflight_last;
        fifo_wr_ptr            <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef OCCUPANCY_READER_THRESHOLD_EN
  cell_class_t fifo_class [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_class[0] <= CLASS_UNKNOWN;
      fifo_class[1] <= CLASS_UNKNOWN;
    end else if (push) begin
      fifo_class[fifo_wr_ptr] <= classify_cell(cell_t'(mem_read_data),
                                               OCC_THRESHOLD, FREE_THRESHOLD);
    end
  end

  assign resp_class = fifo_class[fifo_rd_ptr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_occupancy_reader.sv
// ============================================================================
// Module : tb_occupancy_reader
// Brief  : Directed, table-driven bench for occupancy_reader with a
//          synchronous-read RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_occupancy_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_active;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_x;
  logic [3:0] req_y;
  logic       dump_start;
  logic       dump_busy;
  logic [8:0] mem_address;
  logic [7:0] mem_read_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_last;
`ifdef OCCUPANCY_READER_THRESHOLD_EN
  logic [1:0] resp_class;
  logic [1:0] got_class;
`endif

  logic [7:0] ram [512];
  int n_checks = 0;
  int n_fail   = 0;

  occupancy_reader dut (
    .clock         (clock),
    .reset         (reset),
    .write_active  (write_active),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .dump_start    (dump_start),
    .dump_busy     (dump_busy),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_last     (resp_last)
`ifdef OCCUPANCY_READER_THRESHOLD_EN
    ,
    .resp_class    (resp_class)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_read_data <= ram[mem_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_lookup(input int x, input int y, input int stall, input int rdly,
                           input logic [7:0] exp_data, output int lat,
                           output logic [7:0] data, output logic last);
    int c;
    lat  = -1;
    data = '0;
    last = 1'b0;
    req_valid    = 1'b1;
    req_x        = 5'(x);
    req_y        = 4'(y);
    write_active = (stall > 0);
    resp_ready   = (rdly == 0);
    check("lk_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    c = 1;
    while (lat < 0 && c < 40) begin
      write_active = (c < stall);
      if (resp_valid) begin
        lat = c;
      end else begin
        @(posedge clock); @(negedge clock);
        c++;
      end
    end
    write_active = 1'b0;
    if (lat < 0) begin
      check("lk_timeout", 32'd0, 32'd1);
      resp_ready = 1'b1;
      return;
    end
    data = resp_data;
    last = resp_last;
`ifdef OCCUPANCY_READER_THRESHOLD_EN
    got_class = resp_class;
`endif
    for (int k = 0; k < rdly; k++) begin
      @(posedge clock); @(negedge clock);
      check("lk_hold_valid", 32'(resp_valid), 32'd1);
      check("lk_hold_data", 32'(resp_data), 32'(exp_data));
    end
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    check("lk_pop_empty", 32'(resp_valid), 32'd0);
    check("lk_back_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic run_dump(input int ready_mode, input int wa_mode, input int extra_start,
                          input int abort_at, output int beats, output int last_cycle);
    int bad_order, bad_last, busy_low, first_bad;
    bit done;
    bad_order = 0; bad_last = 0; busy_low = 0; first_bad = -1;
    done = 1'b0;
    beats = 0;
    last_cycle = -1;
    req_valid = 1'b0; write_active = 1'b0; resp_ready = 1'b1;
    dump_start = 1'b1;
    @(posedge clock); @(negedge clock);
    dump_start = 1'b0;
    check("dump_busy_start", 32'(dump_busy), 32'd1);
    for (int c = 0; c < 6000 && !done; c++) begin
      resp_ready   = (ready_mode == 0) ? 1'b1 : (c % 2 == 0);
      write_active = (wa_mode != 0) && (c % 4 == 3);
      dump_start   = (extra_start != 0) && (c == 50);
      if (!dump_busy) busy_low++;
      if (resp_valid && resp_ready) begin
        if (abort_at >= 0 && beats == abort_at) begin
          reset = 1'b1;
          done  = 1'b1;
        end else begin
          if (resp_data != beats[7:0]) begin
            bad_order++;
            if (first_bad < 0) first_bad = beats;
          end
          if (resp_last != (beats == 511)) bad_last++;
          beats++;
          if (resp_last) begin
            done = 1'b1;
            last_cycle = c;
          end
        end
      end
      @(posedge clock); @(negedge clock);
    end
    dump_start = 1'b0; write_active = 1'b0; resp_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("dump_busy_held", 32'(busy_low), 32'd0);
    check("dump_order_errors", 32'(bad_order), 32'd0);
    if (bad_order != 0) $display("  first out-of-order beat %0d", first_bad);
    check("dump_last_errors", 32'(bad_last), 32'd0);
  endtask

  typedef struct {
    int         x;
    int         y;
    int         stall;
    int         rdly;
    logic [7:0] exp_data;
    int         exp_lat;
  } lk_vec_t;

  lk_vec_t vecs [4];

  initial begin
    int lat, beats, last_cycle, busy_seen;
    logic [7:0] data;
    logic last;

    vecs[0] = '{x: 3,  y: 2,  stall: 0, rdly: 0, exp_data: 8'd5,   exp_lat: 2};
    vecs[1] = '{x: 31, y: 15, stall: 0, rdly: 2, exp_data: 8'hFF,  exp_lat: 2};
    vecs[2] = '{x: 0,  y: 0,  stall: 1, rdly: 0, exp_data: 8'h00,  exp_lat: 3};
    vecs[3] = '{x: 17, y: 9,  stall: 3, rdly: 1, exp_data: 8'h31,  exp_lat: 5};

    for (int i = 0; i < 512; i++) ram[i] = 8'(i);
    ram[67] = 8'd5;

    reset = 1'b1; write_active = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    dump_start = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dump_busy", 32'(dump_busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_last", 32'(resp_last), 32'd0);
`ifdef OCCUPANCY_READER_THRESHOLD_EN
    check("rst_resp_class", 32'(resp_class), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      do_lookup(vecs[i].x, vecs[i].y, vecs[i].stall, vecs[i].rdly, vecs[i].exp_data,
                lat, data, last);
      check($sformatf("lk%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("lk%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("lk%0d_last", i), 32'(last), 32'd0);
    end

    // Lookup and dump_start together: lookup wins, dump is dropped.
    req_valid = 1'b1; req_x = 5'd3; req_y = 4'd2; dump_start = 1'b1; resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; dump_start = 1'b0;
    check("simul_no_busy", 32'(dump_busy), 32'd0);
    lat = -1;
    for (int c = 1; c < 20 && lat < 0; c++) begin
      if (resp_valid) lat = c;
      else begin @(posedge clock); @(negedge clock); end
    end
    check("simul_latency", 32'(lat), 32'd2);
    check("simul_data", 32'(resp_data), 32'd5);
    busy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); @(negedge clock);
      if (resp_valid || dump_busy) busy_seen++;
    end
    check("simul_no_dump", 32'(busy_seen), 32'd0);

    ram[67] = 8'd67;

    run_dump(0, 0, 0, -1, beats, last_cycle);
    check("dump_full_beats", 32'(beats), 32'd512);
    check("dump_full_rate", 32'(last_cycle), 32'd513);
    check("dump_full_busy_end", 32'(dump_busy), 32'd0);
    check("dump_full_empty_end", 32'(resp_valid), 32'd0);

    run_dump(1, 1, 1, -1, beats, last_cycle);
    check("dump_stall_beats", 32'(beats), 32'd512);
    check("dump_stall_busy_end", 32'(dump_busy), 32'd0);
    check("dump_stall_ready_end", 32'(req_ready), 32'd1);

    run_dump(0, 0, 0, 100, beats, last_cycle);
    check("abort_beats", 32'(beats), 32'd100);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_dump_busy", 32'(dump_busy), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);

    run_dump(0, 0, 0, -1, beats, last_cycle);
    check("redump_beats", 32'(beats), 32'd512);
    check("redump_busy_end", 32'(dump_busy), 32'd0);

`ifdef OCCUPANCY_READER_THRESHOLD_EN
    ram[1] = 8'd20;  ram[2] = 8'd19;  ram[3] = 8'hEC;  ram[4] = 8'h81;
    do_lookup(1, 0, 0, 0, 8'd20, lat, data, last);
    check("class_p20", 32'(got_class), 32'd2);
    do_lookup(2, 0, 0, 0, 8'd19, lat, data, last);
    check("class_p19", 32'(got_class), 32'd0);
    do_lookup(3, 0, 0, 0, 8'hEC, lat, data, last);
    check("class_m20", 32'(got_class), 32'd1);
    do_lookup(4, 0, 0, 0, 8'h81, lat, data, last);
    check("class_m127", 32'(got_class), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
